// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one spi_master byte engine between NUM_REQ requesters.
// Latches the winning request, holds a start level, waits for done, then acks with read data.
module spi_req_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned START_HOLD  = 4,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [8*NUM_REQ-1:0] req_addr,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 m_start_wr,
    output logic                 m_start_re,
    output logic [7:0]           m_addr,
    output logic [7:0]           m_wdata,
    input  logic [7:0]           m_rdata,
    input  logic                 m_done
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned HW = $clog2(START_HOLD + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_CLR,
        WAIT_DONE,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ptr;
    logic [IW-1:0] grant;
    logic [IW-1:0] pick;
    logic          pick_ok;
    logic          rw;
    logic [HW-1:0] hold_cnt;
    logic [15:0]   to_cnt;
    logic          hold_last;
    logic          to_hit;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        return IW'(s % NUM_REQ);
    endfunction

    // Circular search starting just after the last winner.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!pick_ok && req_valid[wrap_idx(ptr, k)]) begin
                pick    = wrap_idx(ptr, k);
                pick_ok = 1'b1;
            end
        end
    end

    assign hold_last = (hold_cnt == HW'(START_HOLD - 1));
    assign to_hit    = (to_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        m_start_wr = 1'b0;
        m_start_re = 1'b0;
        req_ack    = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_ok) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                m_start_wr = rw;
                m_start_re = !rw;
                if (hold_last) state_nxt = WAIT_CLR;
            end
            WAIT_CLR: begin
                if (to_hit)       state_nxt = RESP;
                else if (!m_done) state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (m_done || to_hit) state_nxt = RESP;
            end
            RESP: begin
                req_ack[grant] = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The response registers double as the capture register, so they
    // change only on the edge that enters RESP and hold until the next one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr       <= IW'(NUM_REQ - 1);
            grant     <= '0;
            rw        <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            hold_cnt  <= '0;
            to_cnt    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    to_cnt   <= '0;
                    if (pick_ok) begin
                        grant   <= pick;
                        rw      <= req_rw[pick];
                        m_addr  <= req_addr[32'(pick)*8 +: 8];
                        m_wdata <= req_rw[pick] ? req_wdata[32'(pick)*8 +: 8] : 8'h00;
                    end
                end
                LAUNCH: begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                WAIT_CLR, WAIT_DONE: begin
                    to_cnt <= to_cnt + 16'd1;
                    if (state == WAIT_DONE && m_done) begin
                        rsp_rdata <= m_rdata;
                        rsp_err   <= 1'b0;
                    end else if (to_hit) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    ptr <= grant;
                end
                default: ;
            endcase
        end
    end

endmodule
